// File: rtl/bram_port_master.sv
// Stream-to-RAM-port initiator: valid/ready requests drive one block RAM port, and
// 1-cycle-latency read data is captured into a 3-entry in-order response FIFO.
module bram_port_master #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout
);

  localparam int unsigned Depth = 3;

  logic [1:0]            count_q, count_d;
  logic [1:0]            wr_ptr_q, rd_ptr_q;
  logic                  inflight_q, inflight_we_q;
  logic                  fifo_write_q [Depth];
  logic [DATA_WIDTH-1:0] fifo_rdata_q [Depth];

  logic       fire, push, pop;
  logic [2:0] occupancy;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Occupancy counts the in-flight op so its completion always has a free slot.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};
  assign req_ready = rst_n & (occupancy <= 3'd2);
  assign fire      = req_valid & req_ready;

  assign bram_en   = fire;
  assign bram_we   = fire & req_we;
  assign bram_addr = req_addr;
  assign bram_din  = req_wdata;

  assign push      = inflight_q;
  assign rsp_valid = (count_q != 2'd0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_write = rsp_valid & fifo_write_q[rd_ptr_q];
  assign rsp_rdata = rsp_valid ? fifo_rdata_q[rd_ptr_q] : '0;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q       <= 2'd0;
      wr_ptr_q      <= 2'd0;
      rd_ptr_q      <= 2'd0;
      inflight_q    <= 1'b0;
      inflight_we_q <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        fifo_write_q[i] <= 1'b0;
        fifo_rdata_q[i] <= '0;
      end
    end else begin
      inflight_q    <= fire;
      inflight_we_q <= fire & req_we;
      count_q       <= count_d;
      if (push) begin
        fifo_write_q[wr_ptr_q] <= inflight_we_q;
        fifo_rdata_q[wr_ptr_q] <= inflight_we_q ? '0 : bram_dout;
        wr_ptr_q               <= next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
    end
  end

  push_never_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && count_q == 2'd3));

endmodule
